// File: rtl/block_mover.sv
// block_mover: a horizontal block that bounces between x=0 and SCREEN_MAX.
// A row starts on load and moves one STEP on each divided tick. A player
// press (synchronized rising edge of stop_btn) freezes the block until the
// downstream logic acknowledges it with next_round.
module block_mover #(
    parameter int unsigned SCREEN_MAX = 159,
    parameter int unsigned STEP       = 4,
    parameter int unsigned TICK_DIV   = 5000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [3:0] load_size,
    input  logic [1:0] speed,
    input  logic       stop_btn,
    input  logic       next_round,
    output logic [8:0] curr_block_start,
    output logic [8:0] curr_block_end,
    output logic [3:0] curr_block_size,
    output logic       stop_true,
    output logic       moving
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MOVE    = 2'd1;
    localparam logic [1:0] ST_STOPPED = 2'd2;

    // Wide enough to hold TICK_DIV itself so the shifted period never truncates.
    localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] TICK_DIV_W = CNT_W'(TICK_DIV);
    localparam logic [8:0] STEP_W = 9'(STEP);
    localparam logic [8:0] MAX_W  = 9'(SCREEN_MAX);

    logic [1:0]       state_q, state_d;
    logic [8:0]       start_q, start_d;
    logic [8:0]       end_q, end_d;
    logic [3:0]       size_q, size_d;
    logic [1:0]       speed_q, speed_d;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]       sync_q;
    logic             btn_prev_q;
    logic             stop_true_q;
    logic             moving_q;

    logic             press;
    logic [CNT_W-1:0] tick_period;
    logic [CNT_W-1:0] tick_last;
    logic [9:0]       start_plus_step;
    logic             up_fits;

    // Press is the rising edge of the synchronized button; a held button
    // never produces a second press, so it cannot stop a later row.
    assign press = sync_q[1] & ~btn_prev_q;

    // Bring the raw button into the clock domain and remember its last value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q     <= 2'b00;
            btn_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], stop_btn};
            btn_prev_q <= sync_q[1];
        end
    end

    // Next-state logic: FSM, tick divider and bounce arithmetic.
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        end_d      = end_q;
        size_d     = size_q;
        speed_d    = speed_q;
        dir_up_d   = dir_up_q;
        tick_cnt_d = tick_cnt_q;

        // A period that shifts down to zero is treated as one clock per tick.
        tick_period = TICK_DIV_W >> speed_q;
        tick_last   = (tick_period == '0) ? '0 : tick_period - CNT_W'(1);

        start_plus_step = {1'b0, start_q} + {1'b0, STEP_W};
        up_fits         = (start_plus_step <= {1'b0, MAX_W});

        case (state_q)
            ST_IDLE: begin
                if (load && (load_size != 4'd0)) begin
                    state_d    = ST_MOVE;
                    start_d    = MAX_W;
                    end_d      = MAX_W - {3'b000, load_size, 2'b00};
                    size_d     = load_size;
                    speed_d    = speed;
                    dir_up_d   = 1'b0;
                    tick_cnt_d = '0;
                end
            end
            ST_MOVE: begin
                // A press wins over a tick in the same cycle, so the
                // position freezes at its pre-tick value.
                if (press) begin
                    state_d = ST_STOPPED;
                end else if (tick_cnt_q == tick_last) begin
                    tick_cnt_d = '0;
                    if (!dir_up_q) begin
                        if (end_q >= STEP_W) begin
                            start_d = start_q - STEP_W;
                            end_d   = end_q - STEP_W;
                        end else begin
                            dir_up_d = 1'b1;
                            start_d  = start_q + STEP_W;
                            end_d    = end_q + STEP_W;
                        end
                    end else begin
                        if (up_fits) begin
                            start_d = start_q + STEP_W;
                            end_d   = end_q + STEP_W;
                        end else begin
                            dir_up_d = 1'b0;
                            start_d  = start_q - STEP_W;
                            end_d    = end_q - STEP_W;
                        end
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                end
            end
            ST_STOPPED: begin
                if (next_round) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; status flags are registered from the next state so
    // they change together with the state itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            start_q     <= 9'd0;
            end_q       <= 9'd0;
            size_q      <= 4'd0;
            speed_q     <= 2'd0;
            dir_up_q    <= 1'b0;
            tick_cnt_q  <= '0;
            stop_true_q <= 1'b0;
            moving_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            end_q       <= end_d;
            size_q      <= size_d;
            speed_q     <= speed_d;
            dir_up_q    <= dir_up_d;
            tick_cnt_q  <= tick_cnt_d;
            stop_true_q <= (state_d == ST_STOPPED);
            moving_q    <= (state_d == ST_MOVE);
        end
    end

    assign curr_block_start = start_q;
    assign curr_block_end   = end_q;
    assign curr_block_size  = size_q;
    assign stop_true        = stop_true_q;
    assign moving           = moving_q;

endmodule

// File: tb/tb_block_mover.sv
// Testbench for block_mover: directed scenarios followed by randomized
// stimulus, all compared against a behavioural model of the block.
module tb_block_mover;

    localparam int SMAX = 39;
    localparam int TDIV = 4;

    logic       clk;
    logic       resetn;
    logic       load;
    logic [3:0] load_size;
    logic [1:0] speed;
    logic       stop_btn;
    logic       next_round;
    logic [8:0] curr_block_start;
    logic [8:0] curr_block_end;
    logic [3:0] curr_block_size;
    logic       stop_true;
    logic       moving;

    int n_checks;
    int n_errors;

    // Behavioural model: mode 0 idle, 1 moving, 2 stopped.
    int m_mode;
    int m_start;
    int m_width;
    int m_size;
    int m_dir;
    int m_period;
    int m_elapsed;
    bit m_hist[$];

    block_mover #(
        .SCREEN_MAX(SMAX),
        .STEP(4),
        .TICK_DIV(TDIV)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .load(load),
        .load_size(load_size),
        .speed(speed),
        .stop_btn(stop_btn),
        .next_round(next_round),
        .curr_block_start(curr_block_start),
        .curr_block_end(curr_block_end),
        .curr_block_size(curr_block_size),
        .stop_true(stop_true),
        .moving(moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_start   = 0;
        m_width   = 0;
        m_size    = 0;
        m_dir     = -1;
        m_period  = 1;
        m_elapsed = 0;
        m_hist    = '{1'b0, 1'b0, 1'b0};
    endtask

    // One bounce step: reflect off x=0 or SCREEN_MAX inside the same tick.
    task automatic model_move();
        int lo;
        lo = m_start - m_width;
        if (m_dir < 0) begin
            if (lo >= 4) m_start -= 4;
            else begin
                m_dir = 1;
                m_start += 4;
            end
        end else begin
            if (m_start + 4 <= SMAX) m_start += 4;
            else begin
                m_dir = -1;
                m_start -= 4;
            end
        end
    endtask

    // Model update for one rising edge using the inputs currently driven.
    // The button is seen two clocks late; a press needs a 0 then 1 sample.
    task automatic model_edge();
        bit press;
        if (!resetn) begin
            model_reset();
            return;
        end
        press = m_hist[1] && !m_hist[2];
        m_hist.push_front(stop_btn);
        void'(m_hist.pop_back());
        case (m_mode)
            0: begin
                if (load && load_size != 4'd0) begin
                    m_mode    = 1;
                    m_size    = int'(load_size);
                    m_width   = 4 * int'(load_size);
                    m_start   = SMAX;
                    m_dir     = -1;
                    m_elapsed = 0;
                    m_period  = TDIV >> speed;
                    if (m_period < 1) m_period = 1;
                end
            end
            1: begin
                if (press) m_mode = 2;
                else begin
                    m_elapsed++;
                    if (m_elapsed % m_period == 0) model_move();
                end
            end
            default: begin
                if (next_round) m_mode = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("start", 32'(curr_block_start), m_start);
        check_val("end", 32'(curr_block_end), m_start - m_width);
        check_val("size", 32'(curr_block_size), m_size);
        check_val("moving", 32'(moving), (m_mode == 1) ? 1 : 0);
        check_val("stop_true", 32'(stop_true), (m_mode == 2) ? 1 : 0);
    endtask

    task automatic step_cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    // Reset asserted between edges must clear outputs without a clock.
    task automatic async_reset();
        resetn = 1'b0;
        model_reset();
        #1;
        check_val("async_start", 32'(curr_block_start), 0);
        check_val("async_end", 32'(curr_block_end), 0);
        check_val("async_stop", 32'(stop_true), 0);
        check_val("async_moving", 32'(moving), 0);
        run_cycles(2);
        resetn = 1'b1;
    endtask

    task automatic pulse_load(input logic [3:0] sz, input logic [1:0] sp);
        load      = 1'b1;
        load_size = sz;
        speed     = sp;
        step_cycle();
        load      = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        resetn     = 1'b0;
        load       = 1'b0;
        load_size  = 4'd0;
        speed      = 2'd0;
        stop_btn   = 1'b0;
        next_round = 1'b0;
        model_reset();

        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        check_val("rst_start", 32'(curr_block_start), 0);
        check_val("rst_moving", 32'(moving), 0);
        resetn = 1'b1;
        $display("reset released");

        pulse_load(4'd3, 2'd0);
        $display("load size=3 speed=0 start=%0d end=%0d", curr_block_start, curr_block_end);
        check_val("load_start", 32'(curr_block_start), 39);
        check_val("load_end", 32'(curr_block_end), 27);
        check_val("load_moving", 32'(moving), 1);
        run_cycles(4);
        check_val("tick1_start", 32'(curr_block_start), 35);
        check_val("tick1_end", 32'(curr_block_end), 23);
        run_cycles(20);
        check_val("low_start", 32'(curr_block_start), 15);
        check_val("low_end", 32'(curr_block_end), 3);
        run_cycles(4);
        $display("bounce at low edge start=%0d end=%0d", curr_block_start, curr_block_end);
        check_val("bounce_lo_start", 32'(curr_block_start), 19);
        check_val("bounce_lo_end", 32'(curr_block_end), 7);
        run_cycles(20);
        check_val("top_start", 32'(curr_block_start), 39);
        run_cycles(4);
        $display("bounce at top edge start=%0d", curr_block_start);
        check_val("bounce_hi_start", 32'(curr_block_start), 35);

        // Press lands exactly on the next tick edge.
        run_cycles(1);
        stop_btn = 1'b1;
        run_cycles(3);
        $display("press on tick edge stop_true=%0d start=%0d", stop_true, curr_block_start);
        check_val("stop_flag", 32'(stop_true), 1);
        check_val("stop_start", 32'(curr_block_start), 35);
        check_val("stop_end", 32'(curr_block_end), 23);
        run_cycles(20);
        check_val("hold_start", 32'(curr_block_start), 35);
        check_val("hold_stop", 32'(stop_true), 1);
        next_round = 1'b1;
        step_cycle();
        next_round = 1'b0;
        $display("next_round stop_true=%0d", stop_true);
        check_val("release_stop", 32'(stop_true), 0);
        check_val("release_moving", 32'(moving), 0);

        // Zero-size load is ignored; load during MOVE is ignored.
        pulse_load(4'd0, 2'd0);
        $display("load size=0 moving=%0d", moving);
        check_val("size0_moving", 32'(moving), 0);
        pulse_load(4'd2, 2'd1);
        pulse_load(4'd5, 2'd0);
        $display("load during move size=%0d", curr_block_size);
        check_val("reload_size", 32'(curr_block_size), 2);
        check_val("reload_width", 32'(curr_block_start) - 32'(curr_block_end), 8);

        // Button still held from before: the new row must keep moving.
        run_cycles(8);
        $display("held button new row moving=%0d", moving);
        check_val("held_moving", 32'(moving), 1);
        stop_btn = 1'b0;
        run_cycles(2);
        stop_btn = 1'b1;
        run_cycles(3);
        $display("fresh press stop_true=%0d", stop_true);
        check_val("fresh_stop", 32'(stop_true), 1);

        async_reset();
        $display("async reset during stop");

        for (int i = 0; i < 3000; i++) begin
            load       = ($urandom_range(0, 5) == 0);
            load_size  = 4'($urandom_range(0, 8));
            speed      = 2'($urandom_range(0, 2));
            next_round = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 499) == 0) async_reset();
            else step_cycle();
        end
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
